cv32e40p_nmr_replica_manager_ft: RTL

CV32E40P_NMR_REPLICA_MANAGER_FT -- requirements
Module: cv32e40p_nmr_replica_manager_ft

---
 rtl/cv32e40p_nmr_replica_manager_ft.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cv32e40p_nmr_replica_manager_ft.sv
// NMR replica manager: votes over up to three active replicas, tracks per-replica
// error history and retires persistently faulty replicas in favour of spares.
module cv32e40p_nmr_replica_manager_ft #(
  parameter int N_REPL       = 4,
  parameter int WIDTH        = 32,
  parameter int CNT_W        = 4,
  parameter int ERR_THRESH   = 8,
  parameter int DECAY_PERIOD = 16,
  parameter int SWAP_CYCLES  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_i,
  input  logic [N_REPL-1:0][WIDTH-1:0] repl_data_i,
  output logic [WIDTH-1:0]             voted_o,
  output logic                         ready_o,
  output logic                         err_detected_o,
  output logic                         err_corrected_o,
  output logic [N_REPL-1:0]            clock_en_o,
  output logic [N_REPL-1:0]            faulty_o,
  output logic [N_REPL-1:0]            perf_fault_o,
  output logic [1:0]                   mode_o
);

  localparam int IDX_W   = $clog2(N_REPL);
  localparam int HC_W    = $clog2(N_REPL + 1);
  localparam int CLEAN_W = $clog2(DECAY_PERIOD + 1);
  localparam int SWAP_W  = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;

  localparam logic [SWAP_W-1:0]  SWAP_LOAD  = SWAP_W'(SWAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   THRESH     = CNT_W'(ERR_THRESH);
  localparam logic [CLEAN_W-1:0] CLEAN_LAST = CLEAN_W'(DECAY_PERIOD - 1);

  typedef enum logic [1:0] {ST_RUN, ST_SWAP, ST_FAIL} state_t;
  typedef enum logic [1:0] {
    MODE_TMR     = 2'b00,
    MODE_DMR     = 2'b01,
    MODE_SIMPLEX = 2'b10,
    MODE_FAIL    = 2'b11
  } mode_t;

  state_t              state_q, state_d;
  logic [SWAP_W-1:0]   swap_q, swap_d;
  logic [CNT_W-1:0]    cnt_q [N_REPL];
  logic [CNT_W-1:0]    cnt_d [N_REPL];
  logic [CLEAN_W-1:0]  clean_q, clean_d;
  logic [N_REPL-1:0]   faulty_q, faulty_d;
  logic [N_REPL-1:0]   perf_q;
  logic [N_REPL-1:0]   new_fault;

  logic [N_REPL-1:0]   active;
  logic [IDX_W-1:0]    slot_idx [3];
  logic [1:0]          n_active;
  logic [HC_W-1:0]     healthy;
  mode_t               mode;

  logic [WIDTH-1:0]    s0, s1, s2;
  logic [WIDTH-1:0]    voted;
  logic [N_REPL-1:0]   mism;
  logic                disagree;
  logic                vote_en;

  // Active set: the first three healthy replicas, mapped to slots in index order.
  always_comb begin
    active   = '0;
    n_active = '0;
    healthy  = '0;
    for (int k = 0; k < 3; k++) slot_idx[k] = '0;
    for (int i = 0; i < N_REPL; i++) begin
      if (!faulty_q[i]) begin
        healthy = healthy + HC_W'(1);
        if (n_active != 2'd3) begin
          active[i]          = 1'b1;
          slot_idx[n_active] = IDX_W'(i);
          n_active           = n_active + 2'd1;
        end
      end
    end
  end

  always_comb begin
    if (healthy >= HC_W'(3))      mode = MODE_TMR;
    else if (healthy == HC_W'(2)) mode = MODE_DMR;
    else if (healthy == HC_W'(1)) mode = MODE_SIMPLEX;
    else                          mode = MODE_FAIL;
  end

  assign s0 = repl_data_i[slot_idx[0]];
  assign s1 = repl_data_i[slot_idx[1]];
  assign s2 = repl_data_i[slot_idx[2]];

  always_comb begin
    voted    = '0;
    mism     = '0;
    disagree = 1'b0;
    case (mode)
      MODE_TMR: begin
        voted = (s0 & s1) | (s0 & s2) | (s1 & s2);
        if (s0 != voted) mism[slot_idx[0]] = 1'b1;
        if (s1 != voted) mism[slot_idx[1]] = 1'b1;
        if (s2 != voted) mism[slot_idx[2]] = 1'b1;
        disagree = |mism;
      end
      MODE_DMR: begin
        voted    = s0;
        disagree = (s0 != s1);
      end
      MODE_SIMPLEX: voted = s0;
      default:      disagree = 1'b1;
    endcase
  end

  assign ready_o         = (state_q == ST_RUN);
  assign err_detected_o  = valid_i && (state_q != ST_SWAP) && disagree;
  assign err_corrected_o = err_detected_o && (mode == MODE_TMR);
  assign voted_o         = voted;
  assign clock_en_o      = active;
  assign faulty_o        = faulty_q;
  assign perf_fault_o    = perf_q;
  assign mode_o          = mode;

  // Only a trustworthy three-way vote may blame or forgive a replica.
  assign vote_en = valid_i && ready_o && (mode == MODE_TMR);

  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (vote_en) begin
      if (disagree) begin
        clean_d = '0;
        for (int i = 0; i < N_REPL; i++)
          if (mism[i] && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (clean_q == CLEAN_LAST) begin
        clean_d = '0;
        for (int i = 0; i < N_REPL; i++)
          if (active[i] && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end else begin
        clean_d = clean_q + CLEAN_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REPL; i++)
      new_fault[i] = !faulty_q[i] && (cnt_d[i] >= THRESH);
  end

  assign faulty_d = faulty_q | new_fault;

  always_comb begin
    state_d = state_q;
    swap_d  = swap_q;
    case (state_q)
      ST_RUN: begin
        if (&faulty_d) begin
          state_d = ST_FAIL;
        end else if (|new_fault) begin
          state_d = ST_SWAP;
          swap_d  = SWAP_LOAD;
        end
      end
      ST_SWAP: begin
        if (&faulty_d)               state_d = ST_FAIL;
        else if (|new_fault)         swap_d  = SWAP_LOAD;
        else if (swap_q == '0)       state_d = ST_RUN;
        else                         swap_d  = swap_q - SWAP_W'(1);
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      swap_q   <= '0;
      cnt_q    <= '{default: '0};
      clean_q  <= '0;
      faulty_q <= '0;
      perf_q   <= '0;
    end else begin
      state_q  <= state_d;
      swap_q   <= swap_d;
      cnt_q    <= cnt_d;
      clean_q  <= clean_d;
      faulty_q <= faulty_d;
      perf_q   <= new_fault;
    end
  end

endmodule
